// File: rtl/sram_playback_reader.sv
// Streams 16-bit words from an asynchronous SRAM (address 0..end_addr, optional looping)
// through a small prefetch FIFO to a strobe-driven consumer.
module sram_playback_reader #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [19:0] end_addr,
  input  logic        loop,
  input  logic        sample_req,
  output logic [19:0] sram_addr,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ce_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n,
  input  logic [15:0] sram_dq,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FIFO_DEPTH - 1);

  // RD_WAIT is the "hold with OE high" point used when the FIFO has no room for another word.
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_CAPTURE, RD_WAIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [19:0] rd_ptr_q, rd_ptr_d;
  logic [19:0] end_addr_q, end_addr_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic        sram_oe_n_q, sram_oe_n_d;
  logic [15:0] sample_out_q, sample_out_d;
  logic        sample_valid_q, sample_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;
  logic [AW-1:0] fifo_wr_q, fifo_wr_d;
  logic [AW-1:0] fifo_rd_q, fifo_rd_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [15:0]   fifo_mem_q [FIFO_DEPTH];

  logic          push, pop, flush, has_space;
  logic [CW-1:0] cnt_after;

  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    end_addr_d     = end_addr_q;
    sram_addr_d    = sram_addr_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    underrun_d     = underrun_q;
    flush          = 1'b0;
    pop            = 1'b0;

    push = (state_q == RD_CAPTURE) && !stop;
    if (busy_q && sample_req && !stop) begin
      if (fifo_cnt_q != '0) pop = 1'b1;
      else                  underrun_d = 1'b1;
    end
    cnt_after = fifo_cnt_q + CW'(push) - CW'(pop);
    has_space = cnt_after <= CNT_LAST;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          end_addr_d = end_addr;
          rd_ptr_d   = '0;
          underrun_d = 1'b0;
          flush      = 1'b1;
          busy_d     = 1'b1;
          state_d    = RD_SETUP;
        end
      end
      RD_SETUP: state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        if (rd_ptr_q == end_addr_q && !loop) begin
          state_d = DRAIN;
        end else begin
          rd_ptr_d = (rd_ptr_q == end_addr_q) ? '0 : rd_ptr_q + 20'd1;
          state_d  = has_space ? RD_SETUP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (has_space) state_d = RD_SETUP;
      end
      DRAIN: begin
        if (cnt_after == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      flush   = 1'b1;
    end

    if (state_d == RD_SETUP) sram_addr_d = rd_ptr_d;
    sram_oe_n_d = !(state_d == RD_SETUP || state_d == RD_CAPTURE);

    if (pop) begin
      sample_out_d   = fifo_mem_q[fifo_rd_q];
      sample_valid_d = 1'b1;
    end

    if (flush) begin
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
    end else begin
      fifo_wr_d  = push ? fifo_wr_q + AW'(1) : fifo_wr_q;
      fifo_rd_d  = pop  ? fifo_rd_q + AW'(1) : fifo_rd_q;
      fifo_cnt_d = cnt_after;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rd_ptr_q       <= '0;
      end_addr_q     <= '0;
      sram_addr_q    <= '0;
      sram_oe_n_q    <= 1'b1;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
      fifo_wr_q      <= '0;
      fifo_rd_q      <= '0;
      fifo_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      end_addr_q     <= end_addr_d;
      sram_addr_q    <= sram_addr_d;
      sram_oe_n_q    <= sram_oe_n_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      underrun_q     <= underrun_d;
      fifo_wr_q      <= fifo_wr_d;
      fifo_rd_q      <= fifo_rd_d;
      fifo_cnt_q     <= fifo_cnt_d;
    end
  end

  // Storage needs no reset: reset forces IDLE, so an interrupted access never writes.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[fifo_wr_q] <= sram_dq;
  end

  assign sram_addr    = sram_addr_q;
  assign sram_oe_n    = sram_oe_n_q;
  assign sram_we_n    = 1'b1;
  assign sram_ce_n    = 1'b0;
  assign sram_lb_n    = 1'b0;
  assign sram_ub_n    = 1'b0;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_sram_playback_reader.sv
// Self-checking bench: expected samples come from the address sequence 0..end_addr
// (wrapping when looping) applied to a behavioural SRAM content function.
module tb_sram_playback_reader;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [19:0] end_addr = '0;
  logic        loop = 1'b0;
  logic        sample_req = 1'b0;
  logic [19:0] sram_addr;
  logic        sram_oe_n, sram_we_n, sram_ce_n, sram_lb_n, sram_ub_n;
  logic [15:0] sram_dq;
  logic [15:0] sample_out;
  logic        sample_valid, busy, done, underrun;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;

  sram_playback_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .end_addr(end_addr), .loop(loop), .sample_req(sample_req),
    .sram_addr(sram_addr), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ce_n(sram_ce_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
    .sram_dq(sram_dq), .sample_out(sample_out), .sample_valid(sample_valid),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [19:0] a);
    logic [15:0] m;
    if (a < 20'd4) begin
      m = a[15:0] + 16'd1;
      return 16'h1111 * m;
    end
    return (a[15:0] * 16'h9E37) ^ 16'h5A5A;
  endfunction

  assign sram_dq = word(sram_addr);

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_play(input logic [19:0] e, input logic l);
    end_addr = e;
    loop = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_req(input logic exp_v, input logic [15:0] exp_d);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    check("sample_valid", sample_valid, exp_v);
    if (exp_v) check("sample_out", sample_out, exp_d);
  endtask

  // Consumer slower than one word per 4 cycles, so the FIFO never runs dry mid-stream.
  task automatic play(input logic [19:0] endv, input logic lp, input int unsigned nreq,
                      input int unsigned gmin, input int unsigned gmax);
    int unsigned d0;
    logic        exp_v;
    logic [19:0] a;
    d0 = done_cnt;
    start_play(endv, lp);
    check("busy_after_start", busy, 1'b1);
    tick(3);
    for (int unsigned k = 0; k < nreq; k++) begin
      exp_v = lp || (k <= endv);
      a = lp ? 20'(k % (int'(endv) + 1)) : 20'(k);
      do_req(exp_v, word(a));
      if (k + 1 < nreq) tick($urandom_range(gmax, gmin));
    end
    if (lp) begin
      stop_pulse();
      check("busy_after_stop", busy, 1'b0);
      tick(2);
      check("done_cnt_stop", done_cnt - d0, 0);
    end else begin
      tick(4);
      check("busy_after_done", busy, 1'b0);
      check("done_cnt", done_cnt - d0, 1);
    end
    check("underrun_clean", underrun, 1'b0);
    check("oe_idle", sram_oe_n, 1'b1);
  endtask

  initial begin
    int unsigned oe_low;
    logic [19:0] max_a;
    logic [19:0] ev;
    logic        lv;

    tick(2);
    check("rst_addr", sram_addr, 0);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_ce_n", sram_ce_n, 0);
    check("rst_lb_ub", {sram_lb_n, sram_ub_n}, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_flags", {sample_valid, busy, done, underrun}, 0);
    reset_n = 1'b1;
    tick(2);

    // four-word single pass, one request every 10 cycles
    play(20'd3, 1'b0, 4, 9, 9);
    // two-word loop
    play(20'd1, 1'b1, 6, 3, 6);
    // single word, with and without looping
    play(20'd0, 1'b0, 2, 3, 5);
    play(20'd0, 1'b1, 4, 3, 5);

    // no consumer: prefetch stops once the FIFO is full
    start_play(20'd31, 1'b0);
    oe_low = 0;
    max_a = '0;
    for (int unsigned i = 0; i < 100; i++) begin
      if (!sram_oe_n) begin
        oe_low++;
        if (sram_addr > max_a) max_a = sram_addr;
      end
      tick();
    end
    check("prefetch_oe_cycles", oe_low, 2 * DEPTH);
    check("prefetch_max_addr", max_a, DEPTH - 1);
    check("prefetch_oe_idle", sram_oe_n, 1);
    do_req(1'b1, word(20'd0));
    do_req(1'b1, word(20'd1));
    stop_pulse();

    // request while FIFO still empty
    start_play(20'd3, 1'b0);
    do_req(1'b0, 16'h0);
    check("underrun_set", underrun, 1);
    stop_pulse();
    check("underrun_sticky", underrun, 1);
    start_play(20'd3, 1'b0);
    check("underrun_cleared", underrun, 0);
    stop_pulse();

    // stop with five words queued; stop beats a simultaneous request
    ev = done_cnt;
    start_play(20'd31, 1'b0);
    tick(10);
    stop = 1'b1;
    sample_req = 1'b1;
    tick();
    stop = 1'b0;
    sample_req = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_no_valid", sample_valid, 0);
    check("stop_oe", sram_oe_n, 1);
    do_req(1'b0, 16'h0);
    check("stop_no_underrun", underrun, 0);
    tick(3);
    check("stop_no_done", done_cnt - ev, 0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      ev = 20'($urandom_range(12, 0));
      lv = 1'($urandom_range(1, 0));
      play(ev, lv, lv ? $urandom_range(20, 3) : int'(ev) + 1 + $urandom_range(2, 0), 3, 10);
    end

    // reset during a capture cycle
    start_play(20'd31, 1'b0);
    tick();
    check("pre_reset_oe", sram_oe_n, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_oe", sram_oe_n, 1);
    check("mid_rst_addr", sram_addr, 0);
    check("mid_rst_sample_out", sample_out, 0);
    check("mid_rst_flags", {sample_valid, busy, done, underrun}, 0);
    tick(2);
    reset_n = 1'b1;
    tick();
    do_req(1'b0, 16'h0);
    check("post_rst_underrun", underrun, 0);
    play(20'd3, 1'b0, 4, 3, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
